// File: rtl/chip_trig_path.sv
// Multi-channel threshold trigger: locks onto one channel on the first qualifying
// crossing and emits a framed burst of pre-trigger history plus live samples.
module chip_trig_path #(
  parameter int unsigned NCH       = 8,
  parameter int unsigned DW        = 16,
  parameter int unsigned LENW      = 20,
  parameter int unsigned PRE_DEPTH = 16,
  localparam int unsigned PW       = $clog2(PRE_DEPTH)
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic [NCH*DW-1:0] sm_data,
  input  logic              sm_vld,
  input  logic              buf_rdy,
  input  logic              cfg_en,
  input  logic              cfg_mode,
  input  logic [DW-1:0]     cfg_chip_th,
  input  logic [LENW-1:0]   cfg_len,
  input  logic [PW-1:0]     cfg_pre,
  input  logic [15:0]       cfg_holdoff,
  output logic [DW-1:0]     d1_data,
  output logic              d1_vld,
  output logic              d1_sof,
  output logic              d1_eof,
  output logic [6:0]        sel_path,
  output logic              busy,
  output logic [15:0]       trig_cnt,
  output logic              ovf
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned RW = LENW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    HOLD
  } state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   rem_q, rem_nxt, rem_first;
  logic [15:0]     hold_q, hold_nxt;
  logic [CW-1:0]   sel_q;
  logic [PW-1:0]   pre_q;

  logic [DW-1:0]   samp [NCH];
  logic [DW-1:0]   ring [NCH][PRE_DEPTH];
  logic [PW-1:0]   wp;
  logic [PW:0]     fill_cnt;

  logic            any_cross;
  logic [CW-1:0]   win_ch;
  logic [DW-1:0]   win_val;

  logic [CW-1:0]   rd_ch;
  logic [PW-1:0]   rd_pre;
  logic [PW-1:0]   rd_idx;
  logic [DW-1:0]   dly_sample;

  logic            trig;
  logic            emit;
  logic            last;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      samp[i] = sm_data[i*DW +: DW];
    end
  end

  // History ring: written every beat regardless of state; fill_cnt gates its use.
  always_ff @(posedge clk_sys) begin
    if (sm_vld) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        ring[i][wp] <= samp[i];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wp       <= '0;
      fill_cnt <= '0;
    end else if (sm_vld) begin
      wp <= wp + PW'(1);
      if (fill_cnt != (PW+1)'(PRE_DEPTH)) begin
        fill_cnt <= fill_cnt + (PW+1)'(1);
      end
    end
  end

  // Mode 0 keeps the first crossing; mode 1 replaces only on a strictly larger
  // sample, so ties resolve to the lowest index.
  always_comb begin
    any_cross = 1'b0;
    win_ch    = '0;
    win_val   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (samp[i] >= cfg_chip_th) begin
        if (!any_cross || (cfg_mode && (samp[i] > win_val))) begin
          any_cross = 1'b1;
          win_ch    = CW'(i);
          win_val   = samp[i];
        end
      end
    end
  end

  always_comb begin
    rd_ch      = (state == IDLE) ? win_ch  : sel_q;
    rd_pre     = (state == IDLE) ? cfg_pre : pre_q;
    rd_idx     = wp - rd_pre;
    dly_sample = (rd_pre == '0) ? samp[rd_ch] : ring[rd_ch][rd_idx];
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem_q;
    hold_nxt  = hold_q;
    trig      = 1'b0;
    emit      = 1'b0;
    rem_first = RW'(cfg_pre) + ((cfg_len == '0) ? RW'(1) : RW'(cfg_len));
    case (state)
      IDLE: begin
        if (sm_vld && cfg_en && buf_rdy && any_cross &&
            (fill_cnt >= (PW+1)'(cfg_pre))) begin
          trig     = 1'b1;
          emit     = 1'b1;
          rem_nxt  = rem_first - RW'(1);
          hold_nxt = cfg_holdoff;
          if (rem_nxt != '0) begin
            state_nxt = FRAME;
          end else if (cfg_holdoff != '0) begin
            state_nxt = HOLD;
          end
        end
      end
      FRAME: begin
        if (sm_vld) begin
          emit    = 1'b1;
          rem_nxt = rem_q - RW'(1);
          if (rem_nxt == '0) begin
            state_nxt = (hold_q != '0) ? HOLD : IDLE;
          end
        end
      end
      HOLD: begin
        if (sm_vld) begin
          hold_nxt = hold_q - 16'd1;
          if (hold_nxt == '0) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    last = emit && (rem_nxt == '0);
  end

  // busy also covers the emitting beat, so a one-beat frame with no hold-off
  // still shows busy alongside sof/eof.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= IDLE;
      rem_q    <= '0;
      hold_q   <= '0;
      sel_q    <= '0;
      pre_q    <= '0;
      d1_data  <= '0;
      d1_vld   <= 1'b0;
      d1_sof   <= 1'b0;
      d1_eof   <= 1'b0;
      sel_path <= '0;
      busy     <= 1'b0;
      trig_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      state  <= state_nxt;
      rem_q  <= rem_nxt;
      hold_q <= hold_nxt;
      if (trig) begin
        sel_q    <= win_ch;
        pre_q    <= cfg_pre;
        sel_path <= 7'(win_ch);
        trig_cnt <= trig_cnt + 16'd1;
      end
      d1_vld  <= emit;
      d1_sof  <= trig;
      d1_eof  <= last;
      d1_data <= emit ? dly_sample : '0;
      busy    <= emit || (state_nxt != IDLE);
      if (emit && !buf_rdy) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chip_trig_path.sv
// Self-checking bench for chip_trig_path: directed scenarios plus random traffic,
// compared each cycle against a beat-history reference model.
module tb_chip_trig_path;

  localparam int unsigned NCH       = 8;
  localparam int unsigned DW        = 16;
  localparam int unsigned LENW      = 20;
  localparam int unsigned PRE_DEPTH = 16;
  localparam int unsigned PW        = 4;

  logic              clk_sys = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] sm_data;
  logic              sm_vld;
  logic              buf_rdy;
  logic              cfg_en;
  logic              cfg_mode;
  logic [DW-1:0]     cfg_chip_th;
  logic [LENW-1:0]   cfg_len;
  logic [PW-1:0]     cfg_pre;
  logic [15:0]       cfg_holdoff;
  logic [DW-1:0]     d1_data;
  logic              d1_vld;
  logic              d1_sof;
  logic              d1_eof;
  logic [6:0]        sel_path;
  logic              busy;
  logic [15:0]       trig_cnt;
  logic              ovf;

  always #5 clk_sys = ~clk_sys;

  chip_trig_path #(
    .NCH(NCH),
    .DW(DW),
    .LENW(LENW),
    .PRE_DEPTH(PRE_DEPTH)
  ) dut (
    .clk_sys(clk_sys),
    .rst(rst),
    .sm_data(sm_data),
    .sm_vld(sm_vld),
    .buf_rdy(buf_rdy),
    .cfg_en(cfg_en),
    .cfg_mode(cfg_mode),
    .cfg_chip_th(cfg_chip_th),
    .cfg_len(cfg_len),
    .cfg_pre(cfg_pre),
    .cfg_holdoff(cfg_holdoff),
    .d1_data(d1_data),
    .d1_vld(d1_vld),
    .d1_sof(d1_sof),
    .d1_eof(d1_eof),
    .sel_path(sel_path),
    .busy(busy),
    .trig_cnt(trig_cnt),
    .ovf(ovf)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: every beat since reset kept in order; a frame is described
  // by its last beat and the last beat of its hold-off window.
  logic [NCH*DW-1:0] hist[$];
  int   b, frame_end, hold_end, m_pre, m_sel, m_trig;
  bit   m_ovf;
  bit   e_vld, e_sof, e_eof, e_busy;
  logic [DW-1:0] e_data;

  logic [DW-1:0] cap[$];
  int   sof_beats[$];
  int   eof_beats[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic logic [NCH*DW-1:0] put(input logic [NCH*DW-1:0] base,
                                            input int ch, input logic [DW-1:0] v);
    logic [NCH*DW-1:0] r;
    r = base;
    r[ch*DW +: DW] = v;
    return r;
  endfunction

  // Mode 0: lowest crossing index. Mode 1: find the largest crossing value,
  // then the lowest index carrying it.
  function automatic int pick(input logic [NCH*DW-1:0] d, input logic [DW-1:0] th,
                              input logic mode);
    int best;
    best = -1;
    for (int i = 0; i < int'(NCH); i++) begin
      if (d[i*DW +: DW] >= th) begin
        if (!mode) return i;
        if (int'(d[i*DW +: DW]) > best) best = int'(d[i*DW +: DW]);
      end
    end
    if (best < 0) return -1;
    for (int i = 0; i < int'(NCH); i++) begin
      if (int'(d[i*DW +: DW]) == best) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    b = 0; frame_end = -1; hold_end = -1;
    m_pre = 0; m_sel = 0; m_trig = 0; m_ovf = 0;
    e_vld = 0; e_sof = 0; e_eof = 0; e_busy = 0; e_data = '0;
  endtask

  task automatic model_step();
    logic [NCH*DW-1:0] hv;
    int ch, len;
    bit emit;
    if (rst) begin
      model_reset();
      return;
    end
    e_vld = 0; e_sof = 0; e_eof = 0; e_data = '0;
    emit = 0;
    if (sm_vld) begin
      hist.push_back(sm_data);
      if (b <= frame_end) begin
        emit = 1;
      end else if (b > hold_end && cfg_en && buf_rdy && b >= int'(cfg_pre)) begin
        ch = pick(sm_data, cfg_chip_th, cfg_mode);
        if (ch >= 0) begin
          m_sel     = ch;
          m_pre     = int'(cfg_pre);
          len       = (cfg_len == 0) ? 1 : int'(cfg_len);
          frame_end = b + m_pre + len - 1;
          hold_end  = frame_end + int'(cfg_holdoff);
          m_trig    = (m_trig + 1) % 65536;
          e_sof     = 1;
          emit      = 1;
        end
      end
      if (emit) begin
        hv     = hist[b - m_pre];
        e_vld  = 1;
        e_data = hv[m_sel*DW +: DW];
        e_eof  = (b == frame_end);
        if (!buf_rdy) m_ovf = 1;
      end
      e_busy = emit || (b < hold_end);
      b++;
    end else begin
      e_busy = (b - 1) < hold_end;
    end
  endtask

  task automatic cycle(input logic vld, input logic [NCH*DW-1:0] d);
    sm_vld  = vld;
    sm_data = d;
    @(posedge clk_sys);
    #1;
    model_step();
    chk("d1_vld",   d1_vld,   e_vld);
    chk("d1_sof",   d1_sof,   e_sof);
    chk("d1_eof",   d1_eof,   e_eof);
    chk("d1_data",  d1_data,  e_data);
    chk("sel_path", sel_path, m_sel);
    chk("busy",     busy,     e_busy);
    chk("trig_cnt", trig_cnt, m_trig);
    chk("ovf",      ovf,      m_ovf);
    if (d1_vld) cap.push_back(d1_data);
    if (d1_sof) sof_beats.push_back(b - 1);
    if (d1_eof) eof_beats.push_back(b - 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, '0);
    rst = 1'b0;
    cap.delete();
    sof_beats.delete();
    eof_beats.delete();
  endtask

  function automatic logic [NCH*DW-1:0] rand_data();
    logic [NCH*DW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NCH); i++) r[i*DW +: DW] = DW'($urandom_range(0, 255));
    return r;
  endfunction

  initial begin
    rst = 1'b1; sm_vld = 1'b0; sm_data = '0; buf_rdy = 1'b1;
    cfg_en = 1'b1; cfg_mode = 1'b0; cfg_chip_th = 16'd100;
    cfg_len = 20'd4; cfg_pre = '0; cfg_holdoff = '0;
    model_reset();
    do_reset();

    // Basic ramp on ch3
    for (int n = 0; n < 8; n++) cycle(1'b1, put('0, 3, DW'(50 * n)));
    chk("basic_len", cap.size() >= 4, 1);
    chk("basic_d0", cap[0], 100);
    chk("basic_d1", cap[1], 150);
    chk("basic_d2", cap[2], 200);
    chk("basic_d3", cap[3], 250);
    chk("basic_eof_beat", eof_beats[0], 5);

    // Pre-trigger history
    do_reset();
    cfg_pre = 4'd3; cfg_len = 20'd2; cfg_chip_th = 16'd10;
    for (int n = 0; n < 16; n++) cycle(1'b1, put('0, 0, DW'(n)));
    for (int k = 0; k < 5; k++) chk("pre_data", cap[k], 7 + k);
    chk("pre_sof_beat", sof_beats[0], 10);
    chk("pre_eof_beat", eof_beats[0], 14);

    // Channel selection modes, single-beat frames
    do_reset();
    cfg_pre = '0; cfg_len = '0; cfg_chip_th = 16'd100; cfg_mode = 1'b0;
    cycle(1'b1, put(put('0, 2, 16'd200), 5, 16'd300));
    chk("mode0_sel", sel_path, 2);
    chk("len0_sof_eof", {d1_sof, d1_eof}, 2'b11);
    cfg_mode = 1'b1;
    cycle(1'b1, put(put('0, 2, 16'd200), 5, 16'd300));
    chk("mode1_sel", sel_path, 5);
    cycle(1'b1, put(put('0, 1, 16'd300), 4, 16'd300));
    chk("mode1_tie", sel_path, 1);
    cfg_mode = 1'b0;

    // Hold-off with continuous crossings
    do_reset();
    cfg_len = 20'd2; cfg_holdoff = 16'd5;
    for (int n = 0; n < 20; n++) cycle(1'b1, put('0, 0, 16'd500));
    chk("hold_gap", sof_beats[1] - eof_beats[0] - 1, 5);
    cfg_holdoff = '0;

    // Trigger gated until enough history
    do_reset();
    cfg_pre = 4'd5; cfg_len = 20'd1;
    for (int n = 0; n < 8; n++) cycle(1'b1, put('0, 0, DW'(500 + n)));
    chk("fill_sof_beat", sof_beats[0], 5);
    chk("fill_data", cap[0], 500);

    // buf_rdy low in IDLE blocks triggers
    do_reset();
    cfg_pre = '0; buf_rdy = 1'b0;
    for (int n = 0; n < 4; n++) cycle(1'b1, put('0, 6, 16'd400));
    chk("rdy_block", sof_beats.size(), 0);
    buf_rdy = 1'b1;
    cycle(1'b1, put('0, 6, 16'd400));
    chk("rdy_release", sof_beats.size(), 1);

    // Overflow: rdy dropped mid-frame, frame still completes
    do_reset();
    cfg_len = 20'd6;
    cycle(1'b1, put('0, 0, 16'd500));
    for (int k = 1; k < 10; k++) begin
      buf_rdy = (k != 3);
      cycle(1'b1, '0);
    end
    buf_rdy = 1'b1;
    chk("ovf_frame_len", cap.size(), 6);
    chk("ovf_set", ovf, 1);
    do_reset();
    chk("ovf_clr", ovf, 0);

    // Reset in the middle of a frame
    cfg_len = 20'd10;
    cycle(1'b1, put('0, 2, 16'd500));
    for (int k = 0; k < 3; k++) cycle(1'b1, '0);
    do_reset();
    chk("rst_vld", d1_vld, 0);
    chk("rst_busy", busy, 0);

    // sm_vld gaps stretch the frame
    cfg_pre = 4'd2; cfg_len = 20'd4; cfg_chip_th = 16'd5;
    for (int n = 0; n < 12; n++) begin
      cycle(1'b1, put('0, 0, DW'(n)));
      cycle(1'b0, rand_data());
    end
    chk("gap_first", cap[0], 3);
    chk("gap_last", cap[5], 8);

    // Random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) begin
        cfg_pre     = PW'($urandom_range(0, 15));
        cfg_len     = LENW'($urandom_range(0, 12));
        cfg_holdoff = 16'($urandom_range(0, 6));
        cfg_chip_th = DW'($urandom_range(150, 260));
        cfg_mode    = 1'($urandom_range(0, 1));
      end
      buf_rdy = ($urandom_range(0, 9) != 0);
      cfg_en  = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle(($urandom_range(0, 3) != 0), rand_data());
    end

    // trig_cnt wrap after 65536 single-beat frames
    do_reset();
    cfg_en = 1'b1; buf_rdy = 1'b1; cfg_chip_th = '0;
    cfg_pre = '0; cfg_len = '0; cfg_holdoff = '0;
    for (int n = 0; n < 65536; n++) cycle(1'b1, '0);
    chk("trig_wrap", trig_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
